// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial loader and its bench.
// Optional feature macro: SERIAL_LOADER_PARITY_EN (appends one even-parity bit per frame).
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 6;

  // Number of serial bit slots one word occupies on the line.
  function automatic int frame_len(input int width);
`ifdef SERIAL_LOADER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/serial_loader6_if.sv
// Load-side handshake bundle for serial_loader6.
// Handshake: a word transfers at a rising clk edge exactly when load_valid and
// load_ready are both high; din must be stable while load_valid is high, and
// load_ready never depends on load_valid.
interface serial_loader6_if
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;

  modport master (
    output din,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  din,
    input  load_valid,
    output load_ready
  );

endinterface

// File: rtl/ser_bitcnt.sv
// Modulo-LEN bit-slot counter with a registered terminal-count flag.
// load restarts a frame at slot 0, clear parks the counter, en advances it.
module ser_bitcnt #(
  parameter int LEN = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  logic [CW-1:0] cnt;

  // Slot counter; tc is precomputed one cycle ahead so it is high during the last slot.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
        tc  <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
        tc  <= ((cnt + 1'b1) == LAST);
      end
    end
  end

endmodule

// File: rtl/serial_loader6.sv
// Parallel-to-serial loader: takes WIDTH-bit words over a valid/ready handshake
// and shifts them out MSB-first on sout, with a one-word holding buffer so that
// consecutive frames leave back to back.
// Optional feature macro: SERIAL_LOADER_PARITY_EN (even-parity bit after data bit 0).
module serial_loader6
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_loader6_if.slave        bus,
  output logic                   sout,
  output logic                   busy,
  output logic                   frame_end,
  output state_t                 state
);

  localparam int FRAME_LEN = frame_len(WIDTH);

  logic [FRAME_LEN-1:0] shreg;
  logic [FRAME_LEN-1:0] hold;
  logic [FRAME_LEN-1:0] frame_word;
  logic                 hold_valid;
  logic                 accept;
  logic                 tc;
  logic                 frame_last;
  logic                 reload;
  logic                 cnt_load;
  logic                 cnt_clear;
  logic                 cnt_en;

  // Only a full holding buffer (or reset) pushes back on the producer.
  assign bus.load_ready = !hold_valid && !rst;
  assign accept         = bus.load_valid && bus.load_ready;

  // Build the on-line image of the incoming word (data, plus parity when enabled).
  always_comb begin
    frame_word = '0;
`ifdef SERIAL_LOADER_PARITY_EN
    frame_word = {bus.din, ^bus.din};
`else
    frame_word = bus.din;
`endif
  end

  // Frame boundary decode and bit-counter control.
  always_comb begin
    frame_last = 1'b0;
    reload     = 1'b0;
    cnt_load   = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    frame_last = (state == SHIFT) && tc;
    reload     = frame_last && (hold_valid || accept);
    cnt_load   = ((state == IDLE) && accept) || reload;
    cnt_clear  = frame_last && !reload;
    cnt_en     = (state == SHIFT);
  end

  // Control FSM, shifter and holding buffer; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= frame_word;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (frame_last) begin
            if (hold_valid) begin
              shreg      <= hold;
              hold_valid <= 1'b0;
            end else if (accept) begin
              shreg <= frame_word;
            end else begin
              shreg <= '0;
              state <= IDLE;
            end
          end else begin
            shreg <= {shreg[FRAME_LEN-2:0], 1'b0};
            if (accept) begin
              hold       <= frame_word;
              hold_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sout      = shreg[FRAME_LEN-1];
  assign busy      = (state == SHIFT);
  assign frame_end = tc;

  ser_bitcnt #(
    .LEN(FRAME_LEN)
  ) u_bitcnt (
    .clk  (clk),
    .rst  (rst),
    .clear(cnt_clear),
    .load (cnt_load),
    .en   (cnt_en),
    .tc   (tc)
  );

endmodule

// File: tb/tb_serial_loader6.sv
// Directed bench for serial_loader6: every accepted word pushes its expected
// serial bits and frame_end marks into a queue, and a negedge monitor pops
// and compares them cycle by cycle (idle cycles must be quiet).
module tb_serial_loader6;
  import serial_pkg::*;

  localparam int WIDTH = DEFAULT_WIDTH;
  localparam int FL    = frame_len(WIDTH);

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   sout;
  logic   busy;
  logic   frame_end;
  state_t state;

  serial_loader6_if #(.WIDTH(WIDTH)) bus ();

  serial_loader6 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sout     (sout),
    .busy     (busy),
    .frame_end(frame_end),
    .state    (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] exp_q[$];   // {frame_end, sout} per expected cycle
  bit         mon_en   = 1'b0;
  logic [1:0] mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line image of a word: data MSB first, then parity when enabled.
  function automatic logic [FL-1:0] frame_bits(input logic [WIDTH-1:0] w);
`ifdef SERIAL_LOADER_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  task automatic push_frame(input logic [FL-1:0] f);
    for (int i = 0; i < FL; i++) exp_q.push_back({logic'(i == FL - 1), f[FL-1-i]});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("busy_in_frame", 32'(busy), 32'(1));
        check("sout_bit", 32'(sout), 32'(mon_e[0]));
        check("frame_end", 32'(frame_end), 32'(mon_e[1]));
      end else begin
        check("idle_quiet", 32'({busy, sout, frame_end}), 32'(0));
      end
    end
  end

  // driver tasks (entered and left at posedge + 1)
  task automatic send_word(input logic [WIDTH-1:0] w, input logic [FL-1:0] f, output int waits);
    logic r;
    bit   done;
    done  = 1'b0;
    waits = 0;
    bus.din        = w;
    bus.load_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      r = bus.load_ready;
      @(posedge clk);
      if (r) done = 1'b1;
      else   waits++;
    end
    check("accept_within_bound", 32'(done), 32'(1));
    if (done) push_frame(f);
    #1;
  endtask

  task automatic idle_bus();
    bus.load_valid = 1'b0;
    bus.din        = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    tick(2);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [FL-1:0] exp1;
`ifdef SERIAL_LOADER_PARITY_EN
    exp1 = 7'b1011001;
`else
    exp1 = 6'b101100;
`endif
    bus.din        = '0;
    bus.load_valid = 1'b0;
    rst            = 1'b1;

    // reset values
    tick(2);
    check("rst_sout", 32'(sout), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_frame_end", 32'(frame_end), 32'(0));
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_ready_low", 32'(bus.load_ready), 32'(0));
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(bus.load_ready), 32'(1));
    mon_en = 1'b1;

    // single word from IDLE
    send_word(6'b101100, exp1, w);
    check("single_no_wait", 32'(w), 32'(0));
    idle_bus();
    wait_drain();
    check("single_back_idle", 32'(state), 32'(IDLE));

    // back-to-back pair
    send_word(6'b111000, frame_bits(6'b111000), w);
    send_word(6'b010101, frame_bits(6'b010101), w);
    check("b2b_ready_low", 32'(bus.load_ready), 32'(0));
    idle_bus();
    wait_drain();

    // backpressure: third word stalls until the first frame's last bit
    send_word(6'b100110, frame_bits(6'b100110), w);
    send_word(6'b110000, frame_bits(6'b110000), w);
    check("bp_second_no_wait", 32'(w), 32'(0));
    send_word(6'b011011, frame_bits(6'b011011), w);
    check("bp_third_stall", 32'(w), 32'(FL - 1));
    idle_bus();
    wait_drain();

    // reset mid-frame with hold full
    send_word(6'b110011, frame_bits(6'b110011), w);
    send_word(6'b101010, frame_bits(6'b101010), w);
    idle_bus();
    check("mid_hold_full", 32'(bus.load_ready), 32'(0));
    tick(1);
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_sout", 32'(sout), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_ready", 32'(bus.load_ready), 32'(1));
    tick(FL + 3);
    check("mid_rst_state", 32'(state), 32'(IDLE));

    // reset and accept in the same cycle: word ignored
    bus.din        = 6'b111111;
    bus.load_valid = 1'b1;
    rst            = 1'b1;
    #1;
    check("rst_acc_ready", 32'(bus.load_ready), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_bus();
    #1;
    check("rst_acc_state", 32'(state), 32'(IDLE));
    check("rst_acc_busy", 32'(busy), 32'(0));
    tick(FL + 2);

    // fresh word after that
    send_word(6'b110000, frame_bits(6'b110000), w);
    idle_bus();
    wait_drain();
    check("final_state", 32'(state), 32'(IDLE));

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
